// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: fetch packet, fetch FSM states and PC helpers.
package rv32i_types;

  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pkt_t;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~(32'(INSTR_BYTES) - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Small FIFO of fetch packets between the request FSM and the instruction queue.
// Head is driven from storage registers, zeroed while empty.
module fetch_skid_buf
  import rv32i_types::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  input  logic       flush,
  output fetch_pkt_t head_pkt,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  fetch_pkt_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          do_push, do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == DEPTH_C);
  assign count = count_reg;

  assign do_pop  = pop && !empty;
  // A full buffer only accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      count_next = count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_pkt;
  end

  assign head_pkt = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_req_ctrl.sv
// Fetch request controller: owns the PC, issues stable imem requests, squashes stale
// responses after redirects and buffers packets. Optional counters: FETCH_PERF_CTR_EN.
module fetch_req_ctrl
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h1eceb000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output fetch_pkt_t  out_pkt
`ifdef FETCH_PERF_CTR_EN
  ,
  output logic [31:0] perf_drop_cnt,
  output logic [31:0] perf_hold_cnt
`endif
);

  localparam int          AW      = $clog2(BUF_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(BUF_DEPTH);
  localparam logic [AW:0] ONE_C   = (AW + 1)'(1);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  addr_reg, addr_next;
  logic         active_reg, active_next;

  logic         resp_ok, push, pop, drop;
  logic [31:0]  redir_pc;
  logic [AW:0]  buf_count, cnt_after_pop;
  logic         buf_full, buf_empty;
  fetch_pkt_t   push_pkt;

  assign imem_addr  = addr_reg;
  assign imem_rmask = {4{active_reg}};

  // The cycle right after reset is in REQ with no request outstanding yet.
  assign resp_ok       = imem_resp && active_reg;
  assign redir_pc      = align_pc(redirect_pc);
  assign pop           = out_valid && out_ready;
  assign cnt_after_pop = buf_count - {{AW{1'b0}}, pop};
  assign push_pkt      = '{pc: pc_reg, instr: imem_rdata};

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    push       = 1'b0;
    drop       = 1'b0;
    unique case (state_reg)
      REQ: begin
        if (redirect_en) begin
          pc_next = redir_pc;
          if (resp_ok) begin
            drop       = 1'b1;
            state_next = REQ;
          end else if (active_reg) begin
            state_next = DRAIN;
          end
        end else if (resp_ok) begin
          push       = 1'b1;
          pc_next    = pc_reg + 32'(INSTR_BYTES);
          state_next = (cnt_after_pop + ONE_C >= DEPTH_C) ? HOLD : REQ;
        end
      end
      DRAIN: begin
        if (redirect_en) pc_next = redir_pc;
        if (resp_ok) begin
          drop       = 1'b1;
          state_next = (!redirect_en && cnt_after_pop >= DEPTH_C) ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (redirect_en) begin
          pc_next    = redir_pc;
          state_next = REQ;
        end else if (cnt_after_pop < DEPTH_C) begin
          state_next = REQ;
        end
      end
      default: state_next = REQ;
    endcase
  end

  // Request port is registered; DRAIN keeps presenting the stale address.
  always_comb begin
    active_next = (state_next != HOLD);
    addr_next   = (state_next == DRAIN) ? addr_reg : pc_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= REQ;
      pc_reg     <= RESET_PC;
      addr_reg   <= RESET_PC;
      active_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      addr_reg   <= addr_next;
      active_reg <= active_next;
    end
  end

  fetch_skid_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push && (!buf_full || pop)),
    .push_pkt (push_pkt),
    .pop      (pop),
    .flush    (redirect_en),
    .head_pkt (out_pkt),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_count)
  );

  assign out_valid = !buf_empty;

`ifdef FETCH_PERF_CTR_EN
  logic [31:0] drop_cnt_reg, hold_cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_reg <= '0;
      hold_cnt_reg <= '0;
    end else begin
      if (drop && drop_cnt_reg != '1) drop_cnt_reg <= drop_cnt_reg + 32'd1;
      if (state_reg == HOLD && hold_cnt_reg != '1) hold_cnt_reg <= hold_cnt_reg + 32'd1;
    end
  end

  assign perf_drop_cnt = drop_cnt_reg;
  assign perf_hold_cnt = hold_cnt_reg;
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Directed self-checking bench for fetch_req_ctrl (default BUF_DEPTH=2, RESET_PC=1eceb000).
module tb_fetch_req_ctrl;

  localparam logic [31:0] RPC = 32'h1eceb000;
  localparam logic [31:0] KEY = 32'h5a5a5a5a;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pkt;
`ifdef FETCH_PERF_CTR_EN
  logic [31:0] perf_drop_cnt, perf_hold_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fetch_req_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rmask  (imem_rmask),
    .imem_resp   (imem_resp),
    .imem_rdata  (imem_rdata),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pkt     (out_pkt)
`ifdef FETCH_PERF_CTR_EN
    ,
    .perf_drop_cnt (perf_drop_cnt),
    .perf_hold_cnt (perf_hold_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic respond();
    imem_resp  = 1'b1;
    imem_rdata = imem_addr ^ KEY;
  endtask

  task automatic idle();
    imem_resp  = 1'b0;
    imem_rdata = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b0; idle(); redirect_en = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); redirect_en = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    tick();
    nvec++; if (imem_rmask !== 4'h0) begin nerr++; $display("FAIL reset_rmask got %h want 0", imem_rmask); end
    nvec++; if (imem_addr !== RPC) begin nerr++; $display("FAIL reset_addr got %h want %h", imem_addr, RPC); end
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", out_valid); end
    nvec++; if (out_pkt !== 64'h0) begin nerr++; $display("FAIL reset_pkt got %h want 0", out_pkt); end
    rst = 1'b1;
    tick();
    nvec++; if (imem_rmask !== 4'hf || imem_addr !== RPC) begin nerr++;
      $display("FAIL first_req got %h/%h want f/%h", imem_rmask, imem_addr, RPC); end
    $display("test_reset done");
  endtask

  task automatic test_stream();
    logic [31:0] ppc;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      nvec++; if (imem_rmask !== 4'hf || imem_addr !== RPC + 32'(4 * k)) begin nerr++;
        $display("FAIL stream_addr[%0d] got %h/%h want f/%h", k, imem_rmask, imem_addr, RPC + 32'(4 * k)); end
      if (k > 0) begin
        ppc = RPC + 32'(4 * (k - 1));
        nvec++; if (out_valid !== 1'b1 || out_pkt !== {ppc, ppc ^ KEY}) begin nerr++;
          $display("FAIL stream_pkt[%0d] got %b/%h want 1/%h", k, out_valid, out_pkt, {ppc, ppc ^ KEY}); end
      end
      respond();
      tick();
    end
    idle();
    $display("test_stream done");
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    respond(); tick();
    nvec++; if (imem_addr !== RPC + 32'd4) begin nerr++; $display("FAIL bp_addr1 got %h want %h", imem_addr, RPC + 32'd4); end
    respond(); tick(); idle();
    nvec++; if (imem_rmask !== 4'h0) begin nerr++; $display("FAIL bp_hold got %h want 0", imem_rmask); end
    nvec++; if (out_pkt[63:32] !== RPC) begin nerr++; $display("FAIL bp_head got %h want %h", out_pkt[63:32], RPC); end
    tick();
    nvec++; if (imem_rmask !== 4'h0) begin nerr++; $display("FAIL bp_hold2 got %h want 0", imem_rmask); end
    out_ready = 1'b1;
    tick();
    nvec++; if (imem_rmask !== 4'hf || imem_addr !== RPC + 32'd8) begin nerr++;
      $display("FAIL bp_resume got %h/%h want f/%h", imem_rmask, imem_addr, RPC + 32'd8); end
    nvec++; if (out_pkt[63:32] !== RPC + 32'd4) begin nerr++; $display("FAIL bp_second got %h want %h", out_pkt[63:32], RPC + 32'd4); end
    respond(); tick(); idle();
    nvec++; if (out_valid !== 1'b1 || out_pkt[63:32] !== RPC + 32'd8) begin nerr++;
      $display("FAIL bp_third got %b/%h want 1/%h", out_valid, out_pkt[63:32], RPC + 32'd8); end
    nvec++; if (imem_addr !== RPC + 32'd12) begin nerr++; $display("FAIL bp_next got %h want %h", imem_addr, RPC + 32'd12); end
    $display("test_backpressure done");
  endtask

  task automatic test_redirect_pending();
    do_reset();
    out_ready = 1'b1;
    respond(); tick();
    respond(); tick(); idle();
    redirect_en = 1'b1; redirect_pc = 32'h1eceb100;
    tick();
    redirect_en = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rp_flush got %b want 0", out_valid); end
    for (int k = 0; k < 3; k++) begin
      nvec++; if (imem_rmask !== 4'hf || imem_addr !== RPC + 32'd8) begin nerr++;
        $display("FAIL rp_hold[%0d] got %h/%h want f/%h", k, imem_rmask, imem_addr, RPC + 32'd8); end
      if (k < 2) tick();
    end
    respond(); tick(); idle();
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rp_dropped got %b want 0", out_valid); end
    nvec++; if (imem_addr !== 32'h1eceb100) begin nerr++; $display("FAIL rp_newaddr got %h want 1eceb100", imem_addr); end
    respond(); tick(); idle();
    nvec++; if (out_valid !== 1'b1 || out_pkt !== {32'h1eceb100, 32'h1eceb100 ^ KEY}) begin nerr++;
      $display("FAIL rp_pkt got %b/%h want 1/%h", out_valid, out_pkt, {32'h1eceb100, 32'h1eceb100 ^ KEY}); end
    $display("test_redirect_pending done");
  endtask

  task automatic test_redirect_with_resp();
    do_reset();
    out_ready = 1'b0;
    respond(); tick();
    nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL rr_pre got %b want 1", out_valid); end
    respond(); redirect_en = 1'b1; redirect_pc = 32'h1eceb203;
    tick(); idle(); redirect_en = 1'b0;
    nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rr_flush got %b want 0", out_valid); end
    nvec++; if (imem_rmask !== 4'hf || imem_addr !== 32'h1eceb200) begin nerr++;
      $display("FAIL rr_addr got %h/%h want f/1eceb200", imem_rmask, imem_addr); end
    $display("test_redirect_with_resp done");
  endtask

  task automatic test_async_reset_drain();
    do_reset();
    out_ready = 1'b1;
    redirect_en = 1'b1; redirect_pc = 32'h1eceb300;
    tick(); redirect_en = 1'b0;
    nvec++; if (imem_rmask !== 4'hf || imem_addr !== RPC) begin nerr++;
      $display("FAIL ar_drain got %h/%h want f/%h", imem_rmask, imem_addr, RPC); end
    #2 rst = 1'b0;
    #1;
    nvec++; if (imem_rmask !== 4'h0 || imem_addr !== RPC || out_valid !== 1'b0 || out_pkt !== 64'h0) begin nerr++;
      $display("FAIL ar_async got %h/%h/%b/%h want 0/%h/0/0", imem_rmask, imem_addr, out_valid, out_pkt, RPC); end
    tick();
    rst = 1'b1;
    tick();
    nvec++; if (imem_rmask !== 4'hf || imem_addr !== RPC) begin nerr++;
      $display("FAIL ar_restart got %h/%h want f/%h", imem_rmask, imem_addr, RPC); end
    $display("test_async_reset_drain done");
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    respond(); redirect_en = 1'b1; redirect_pc = 32'hfffffffe;
    tick(); redirect_en = 1'b0;
    nvec++; if (imem_addr !== 32'hfffffffc) begin nerr++; $display("FAIL wrap_a got %h want fffffffc", imem_addr); end
    respond(); tick();
    nvec++; if (imem_addr !== 32'h0 || out_pkt[63:32] !== 32'hfffffffc) begin nerr++;
      $display("FAIL wrap_b got %h/%h want 0/fffffffc", imem_addr, out_pkt[63:32]); end
    respond(); tick(); idle();
    nvec++; if (imem_addr !== 32'h4 || out_pkt[63:32] !== 32'h0) begin nerr++;
      $display("FAIL wrap_c got %h/%h want 4/0", imem_addr, out_pkt[63:32]); end
    $display("test_wrap done");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_pending();
    test_redirect_with_resp();
    test_async_reset_drain();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
